button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter CNT_MAX, default 20'd500000, setting debounce stability time in Clk cycles (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 SHALL have port Clk  input  1  system clock; the block uses this one clock only.
REQ-003 SHALL have port Reset  input  1  synchronous active-high reset (power-on/board reset).
REQ-004 SHALL have port KEY  input  3  raw active-low pushbuttons, asynchronous to Clk; KEY[0]=reset button, KEY[1]=Run button, KEY[2]=Continue button.
REQ-005 SHALL have port Reset_h  output  1  active-high level: debounced KEY[0] pressed OR Reset.
REQ-006 SHALL have port Run  output  1  active-high level: debounced KEY[1] pressed.
REQ-007 SHALL have port Continue  output  1  active-high level: debounced KEY[2] pressed.
REQ-008 SHALL have port Run_pulse  output  1  one-cycle strobe on debounced KEY[1] press.
REQ-009 SHALL have port Continue_pulse  output  1  one-cycle strobe on debounced KEY[2] press.

Function
REQ-010 SHALL pass each KEY bit through a two-flop synchronizer; the second-stage output is the channel's sync signal (1 = released).
REQ-011 SHALL run three independent identical channels, each with a 20-bit counter and an FSM with states RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING.
REQ-012 RELEASED: sync=0 -> PRESS_PENDING with counter cleared to 0; else remain.
REQ-013 PRESS_PENDING: sync=1 -> RELEASED, counter cleared; sync=0 and counter=CNT_MAX-1 -> PRESSED, counter cleared; otherwise counter increments.
REQ-014 PRESSED: sync=1 -> RELEASE_PENDING with counter cleared; else remain.
REQ-015 RELEASE_PENDING: sync=0 -> PRESSED, counter cleared; sync=1 and counter=CNT_MAX-1 -> RELEASED, counter cleared; otherwise counter increments.
REQ-016 Channel level output SHALL be registered and equal 1 exactly while the FSM is in PRESSED or RELEASE_PENDING.
REQ-017 Pulse output SHALL be registered, high for exactly one cycle, namely the first cycle the level output is 1; no pulse on release.
REQ-018 Latency: after KEY goes and stays low, level SHALL rise exactly CNT_MAX+3 Clk edges after the first edge that samples the low value; release latency identical.
REQ-019 Any bounce (sync reverting) during a pending state SHALL abort to the prior stable state with no level change and no pulse.
REQ-020 The counter SHALL never exceed CNT_MAX-1 and SHALL never wrap.
REQ-021 Channels SHALL be fully independent; simultaneous presses produce simultaneous outputs with no priority.
REQ-022 Reset_h SHALL be the combinational OR of Reset and the KEY[0] channel level, so Reset_h is 1 throughout Reset.
REQ-023 A key held through reset deassertion SHALL be detected as a fresh press (level rise plus pulse) per REQ-018 timing.

Reset
REQ-024 While Reset=1 at a Clk edge: synchronizer flops <= 1, FSMs <= RELEASED, counters <= 0, Run/Continue/Run_pulse/Continue_pulse <= 0.
REQ-025 Reset asserted mid-debounce or mid-press SHALL discard all progress; no pulse is emitted in the cycle after Reset deasserts.

Verification (CNT_MAX=4 unless noted)
REQ-026 Clean press: KEY[1] 1->0 held -> Run rises exactly 7 edges after the first sampling edge, Run_pulse high that cycle only; Continue and Reset_h stay 0.
REQ-027 Bounce: KEY[2] low for 3 cycles then high for 1, repeated 5 times, then low held -> no Continue activity until 7 edges after the final low; exactly one Continue_pulse.
REQ-028 Release: after Run=1, KEY[1] high held -> Run falls after 7 edges, no pulse; a 2-cycle high glitch leaves Run=1 with no second pulse.
REQ-029 Simultaneous: KEY[1] and KEY[2] low on the same edge -> Run and Continue rise on the same cycle, both pulses coincide.
REQ-030 Reset mid-operation: assert Reset with KEY[2] low, counter at 2 -> all outputs 0 and Reset_h=1; deassert with KEY[2] held low -> Continue rises 7 edges after the first post-reset sampling edge.
REQ-031 Reset key: KEY[0] low held -> Reset_h rises after 7 edges, Run/Continue unaffected; CNT_MAX=500000 smoke run shows 500003-edge latency.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: conditions three raw active-low pushbuttons into clean
// active-high levels and single-cycle press strobes. Each key passes through
// a two-flop synchronizer and a four-state debounce FSM. A change is accepted
// only after the synchronized value has disagreed with the stable state for
// CNT_MAX+1 consecutive samples.
module button_conditioner #(
  parameter logic [19:0] CNT_MAX = 20'd500000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] KEY,
  output logic       Reset_h,
  output logic       Run,
  output logic       Continue,
  output logic       Run_pulse,
  output logic       Continue_pulse
);

  // The pending states count up to this value before committing a change.
  localparam logic [19:0] CntLast = CNT_MAX - 20'd1;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PENDING,
    PRESSED,
    RELEASE_PENDING
  } state_t;

  // Synchronizer stages. A value of 1 means the key is released.
  logic [2:0]  meta_q;
  logic [2:0]  sync_q;

  // Per-channel debounce state.
  state_t      state_q [3];
  state_t      state_d [3];
  logic [19:0] cnt_q   [3];
  logic [19:0] cnt_d   [3];

  // Registered outputs. Only the Run and Continue channels produce strobes.
  logic [2:0]  level_q;
  logic [2:0]  level_d;
  logic [2:1]  pulse_q;
  logic [2:1]  pulse_d;

  // Two-flop synchronizer that brings the asynchronous keys into the Clk domain.
  // Reset loads 1 (released), so a key held during reset shows up as a fresh press.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta_q <= 3'b111;
      sync_q <= 3'b111;
    end else begin
      meta_q <= KEY;
      sync_q <= meta_q;
    end
  end

  // State, counter and output registers for all three channels.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int ch = 0; ch < 3; ch++) begin
        state_q[ch] <= RELEASED;
        cnt_q[ch]   <= '0;
      end
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // Debounce next-state logic. Any sample that agrees with the stable state
  // aborts a pending change. The counter is cleared on every state change and
  // stops at CntLast, so it can never wrap.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      case (state_q[ch])
        RELEASED: begin
          if (!sync_q[ch]) begin
            state_d[ch] = PRESS_PENDING;
            cnt_d[ch]   = '0;
          end
        end
        PRESS_PENDING: begin
          if (sync_q[ch]) begin
            state_d[ch] = RELEASED;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CntLast) begin
            state_d[ch] = PRESSED;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch]   = cnt_q[ch] + 20'd1;
          end
        end
        PRESSED: begin
          if (sync_q[ch]) begin
            state_d[ch] = RELEASE_PENDING;
            cnt_d[ch]   = '0;
          end
        end
        RELEASE_PENDING: begin
          if (!sync_q[ch]) begin
            state_d[ch] = PRESSED;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CntLast) begin
            state_d[ch] = RELEASED;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch]   = cnt_q[ch] + 20'd1;
          end
        end
        default: begin
          state_d[ch] = RELEASED;
          cnt_d[ch]   = '0;
        end
      endcase
    end
  end

  // Output next values are derived from the next state. This keeps the registered
  // level aligned with the state register rather than one cycle behind it. A
  // strobe fires only on a committed press, never on release or on recovery
  // from a release glitch.
  always_comb begin
    level_d = '0;
    pulse_d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      level_d[ch] = (state_d[ch] == PRESSED) || (state_d[ch] == RELEASE_PENDING);
    end
    for (int ch = 1; ch < 3; ch++) begin
      pulse_d[ch] = (state_q[ch] == PRESS_PENDING) && (state_d[ch] == PRESSED);
    end
  end

  assign Reset_h        = Reset | level_q[0];
  assign Run            = level_q[1];
  assign Continue       = level_q[2];
  assign Run_pulse      = pulse_q[1];
  assign Continue_pulse = pulse_q[2];

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios with literal expectations, followed by
// randomized key and reset activity. A behavioural model runs alongside the
// DUT and is compared with it on every cycle.
module tb_button_conditioner;

  localparam int CntMax = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] KEY;
  logic       Reset_h;
  logic       Run;
  logic       Continue;
  logic       Run_pulse;
  logic       Continue_pulse;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEnable = 0;

  // Model state. The model uses a two-sample delay line, a stable pressed flag
  // per key, and a count of consecutive samples that disagree with that flag.
  bit mSync1  [3];
  bit mSync2  [3];
  bit mPressed[3];
  bit mPulse  [3];
  int mRun    [3];
  bit disagree;

  int runPulseCount  = 0;
  int contPulseCount = 0;
  int pulseBase;
  int holdLeft[3];
  int resetLeft;
  logic [2:0] keyVal;

  button_conditioner #(.CNT_MAX(20'd4)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .KEY            (KEY),
    .Reset_h        (Reset_h),
    .Run            (Run),
    .Continue       (Continue),
    .Run_pulse      (Run_pulse),
    .Continue_pulse (Continue_pulse)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%b expected=%b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Changes the inputs between clock edges. Each call is followed by
  // waitAfterEdges(k), so the value is held for exactly k rising edges.
  task automatic applyStimulus(input logic [2:0] keys, input logic rst);
    @(negedge Clk);
    #1;
    KEY   = keys;
    Reset = rst;
  endtask

  task automatic waitAfterEdges(input int k);
    repeat (k) @(posedge Clk);
    #1;
  endtask

  // Behavioural model. A change is accepted once the key has disagreed with
  // the stable state for CntMax+1 consecutive synchronized samples.
  always @(posedge Clk) begin
    for (int ch = 0; ch < 3; ch++) begin
      if (Reset) begin
        mSync1[ch]   = 1'b1;
        mSync2[ch]   = 1'b1;
        mPressed[ch] = 1'b0;
        mPulse[ch]   = 1'b0;
        mRun[ch]     = 0;
      end else begin
        disagree   = (mSync2[ch] == 1'b0) != mPressed[ch];
        mPulse[ch] = 1'b0;
        if (disagree) begin
          mRun[ch]++;
          if (mRun[ch] == CntMax + 1) begin
            mPressed[ch] = !mPressed[ch];
            mPulse[ch]   = mPressed[ch];
            mRun[ch]     = 0;
          end
        end else begin
          mRun[ch] = 0;
        end
        mSync2[ch] = mSync1[ch];
        mSync1[ch] = KEY[ch];
      end
    end
  end

  // Compares every DUT output with the model on each falling edge.
  always @(negedge Clk) begin
    if (checkEnable) begin
      checkOutput("model Reset_h", Reset_h, Reset | mPressed[0]);
      checkOutput("model Run", Run, mPressed[1]);
      checkOutput("model Continue", Continue, mPressed[2]);
      checkOutput("model Run_pulse", Run_pulse, mPulse[1]);
      checkOutput("model Continue_pulse", Continue_pulse, mPulse[2]);
    end
  end

  // Counts strobes so that the scenarios can check how many occurred.
  always @(negedge Clk) begin
    if (Run_pulse === 1'b1) runPulseCount++;
    if (Continue_pulse === 1'b1) contPulseCount++;
  end

  initial begin
    KEY   = 3'b111;
    Reset = 1'b1;
    waitAfterEdges(2);
    checkEnable = 1;
    checkOutput("reset Reset_h", Reset_h, 1'b1);
    checkOutput("reset Run", Run, 1'b0);
    checkOutput("reset Continue", Continue, 1'b0);
    checkOutput("reset Run_pulse", Run_pulse, 1'b0);
    checkOutput("reset Continue_pulse", Continue_pulse, 1'b0);

    applyStimulus(3'b111, 1'b0);
    waitAfterEdges(10);
    checkOutput("idle Reset_h", Reset_h, 1'b0);

    // Clean press on Run.
    applyStimulus(3'b101, 1'b0);
    waitAfterEdges(6);
    checkOutput("press Run edge6", Run, 1'b0);
    checkOutput("press Run_pulse edge6", Run_pulse, 1'b0);
    waitAfterEdges(1);
    checkOutput("press Run edge7", Run, 1'b1);
    checkOutput("press Run_pulse edge7", Run_pulse, 1'b1);
    checkOutput("press Continue", Continue, 1'b0);
    checkOutput("press Reset_h", Reset_h, 1'b0);
    waitAfterEdges(1);
    checkOutput("press Run_pulse edge8", Run_pulse, 1'b0);
    checkOutput("press Run edge8", Run, 1'b1);

    // A two-cycle release glitch leaves Run high and produces no new strobe.
    pulseBase = runPulseCount;
    applyStimulus(3'b111, 1'b0);
    waitAfterEdges(2);
    applyStimulus(3'b101, 1'b0);
    waitAfterEdges(12);
    checkOutput("glitch Run", Run, 1'b1);
    checkCount("glitch Run pulses", runPulseCount - pulseBase, 0);

    // Release of Run.
    pulseBase = runPulseCount;
    applyStimulus(3'b111, 1'b0);
    waitAfterEdges(6);
    checkOutput("release Run edge6", Run, 1'b1);
    waitAfterEdges(1);
    checkOutput("release Run edge7", Run, 1'b0);
    waitAfterEdges(5);
    checkCount("release Run pulses", runPulseCount - pulseBase, 0);

    // Continue key bounces, then is held low.
    pulseBase = contPulseCount;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b011, 1'b0);
      waitAfterEdges(3);
      applyStimulus(3'b111, 1'b0);
      waitAfterEdges(1);
      checkOutput("bounce Continue", Continue, 1'b0);
    end
    applyStimulus(3'b011, 1'b0);
    waitAfterEdges(6);
    checkOutput("bounce Continue edge6", Continue, 1'b0);
    checkCount("bounce pulses before", contPulseCount - pulseBase, 0);
    waitAfterEdges(1);
    checkOutput("bounce Continue edge7", Continue, 1'b1);
    checkOutput("bounce Continue_pulse edge7", Continue_pulse, 1'b1);
    waitAfterEdges(4);
    checkCount("bounce pulses total", contPulseCount - pulseBase, 1);
    applyStimulus(3'b111, 1'b0);
    waitAfterEdges(10);
    checkOutput("bounce released", Continue, 1'b0);

    // Run and Continue pressed on the same edge.
    applyStimulus(3'b001, 1'b0);
    waitAfterEdges(6);
    checkOutput("simul Run edge6", Run, 1'b0);
    checkOutput("simul Continue edge6", Continue, 1'b0);
    waitAfterEdges(1);
    checkOutput("simul Run", Run, 1'b1);
    checkOutput("simul Continue", Continue, 1'b1);
    checkOutput("simul Run_pulse", Run_pulse, 1'b1);
    checkOutput("simul Continue_pulse", Continue_pulse, 1'b1);
    applyStimulus(3'b111, 1'b0);
    waitAfterEdges(10);

    // Reset in the middle of a Continue debounce, with the key still held.
    applyStimulus(3'b011, 1'b0);
    waitAfterEdges(5);
    applyStimulus(3'b011, 1'b1);
    waitAfterEdges(2);
    checkOutput("midreset Reset_h", Reset_h, 1'b1);
    checkOutput("midreset Continue", Continue, 1'b0);
    checkOutput("midreset Continue_pulse", Continue_pulse, 1'b0);
    checkOutput("midreset Run", Run, 1'b0);
    applyStimulus(3'b011, 1'b0);
    waitAfterEdges(6);
    checkOutput("postreset Continue edge6", Continue, 1'b0);
    waitAfterEdges(1);
    checkOutput("postreset Continue edge7", Continue, 1'b1);
    checkOutput("postreset Continue_pulse edge7", Continue_pulse, 1'b1);
    applyStimulus(3'b111, 1'b0);
    waitAfterEdges(10);

    // Reset pushbutton.
    applyStimulus(3'b110, 1'b0);
    waitAfterEdges(6);
    checkOutput("resetkey Reset_h edge6", Reset_h, 1'b0);
    waitAfterEdges(1);
    checkOutput("resetkey Reset_h edge7", Reset_h, 1'b1);
    checkOutput("resetkey Run", Run, 1'b0);
    checkOutput("resetkey Continue", Continue, 1'b0);
    applyStimulus(3'b111, 1'b0);
    waitAfterEdges(10);

    // Randomized hold lengths per key, with occasional resets. Short holds
    // exercise aborted debounces and long holds exercise committed changes.
    keyVal    = 3'b111;
    resetLeft = 0;
    for (int ch = 0; ch < 3; ch++) holdLeft[ch] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (holdLeft[ch] == 0) begin
          keyVal[ch]   = 1'($urandom_range(0, 1));
          holdLeft[ch] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 14);
        end
        holdLeft[ch]--;
      end
      if (resetLeft > 0) begin
        resetLeft--;
      end else if ($urandom_range(0, 299) == 0) begin
        resetLeft = $urandom_range(1, 3);
      end
      applyStimulus(keyVal, resetLeft > 0);
      waitAfterEdges(1);
    end

    applyStimulus(3'b111, 1'b0);
    waitAfterEdges(10);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
